// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and position helpers.
// Used by vga_timing_gen and by vga_bitchange for its visible-area bounds.
package vga_pkg;

    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 515;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t h;
        cnt_t v;
    } raster_pos_t;

    // Half-open span test: lo <= x < hi.
    function automatic logic in_span(cnt_t x, int lo, int hi);
        return (x >= cnt_t'(lo)) && (x < cnt_t'(hi));
    endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate enable: one-clk pix_en pulse every CLK_DIV clocks, registered.
// Latency: first pulse in the 4th clk after reset release; no backpressure (free-running).
module pix_clk_en #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    always_comb begin
        div_nxt = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + 1'b1;
    end

    // pix_en is decoded from the next divider value so it is high exactly while div == CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= div_nxt;
            pix_en <= (div_nxt == DIV_W'(CLK_DIV - 1));
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: counters, syncs, bright and line/frame start pulses, all registered.
// Latency: every output coherent with hCount/vCount in the same clk; no backpressure (free-running).
module vga_timing_gen #(
    parameter int CLK_DIV     = vga_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_VIS_START = vga_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_VIS_START = vga_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_pkg::V_VIS_END
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       line_start,
    output logic       frame_start
);

    import vga_pkg::*;

    raster_pos_t pos_q;
    raster_pos_t pos_nxt;
    logic        wrap_h;
    logic        wrap_v;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en)
    );

    always_comb begin
        wrap_h  = (pos_q.h == cnt_t'(H_TOTAL - 1));
        wrap_v  = (pos_q.v == cnt_t'(V_TOTAL - 1));
        pos_nxt = pos_q;
        if (pix_en) begin
            if (wrap_h) begin
                pos_nxt.h = '0;
                pos_nxt.v = wrap_v ? '0 : pos_q.v + cnt_t'(1);
            end else begin
                pos_nxt.h = pos_q.h + cnt_t'(1);
            end
        end
    end

    // Decode from pos_nxt so syncs/bright land in the same clk as the counters they describe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_q       <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pos_q       <= pos_nxt;
            hSync       <= (pos_nxt.h >= cnt_t'(H_SYNC));
            vSync       <= (pos_nxt.v >= cnt_t'(V_SYNC));
            bright      <= in_span(pos_nxt.h, H_VIS_START, H_VIS_END) &&
                           in_span(pos_nxt.v, V_VIS_START, V_VIS_END);
            line_start  <= pix_en && wrap_h;
            frame_start <= pix_en && wrap_h && wrap_v;
        end
    end

    assign hCount = pos_q.h;
    assign vCount = pos_q.v;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the raster interface that feeds vga_bitchange. Generates hCount, vCount, bright, hSync and vSync for 640x480 @ 60 Hz from the 100 MHz board clock.
- Also emits line_start and frame_start pulses, so game logic (block motion, score latching) can step once per frame instead of free-running counters.
- Sits between the board clock and both the pixel/colour logic and the VGA connector.

Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz pixel enable)
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hSync low width in pixels (hCount 0..95)
- H_VIS_START, 144, first visible hCount
- H_VIS_END, 784, first non-visible hCount after the active region (exclusive)
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vSync low width in lines (vCount 0..1)
- V_VIS_START, 35, first visible vCount
- V_VIS_END, 515, first non-visible vCount after the active region (exclusive)

Ports:
- clk  in  1  board clock, 100 MHz
- reset_n  in  1  synchronous active-low reset
- pix_en  out  1  one-clk pulse every CLK_DIV clocks; counters advance on it
- hCount  out  10  horizontal position, 0..H_TOTAL-1
- vCount  out  10  vertical position, 0..V_TOTAL-1
- hSync  out  1  active-low horizontal sync
- vSync  out  1  active-low vertical sync
- bright  out  1  high when (hCount,vCount) is in the visible window
- line_start  out  1  one-clk pulse when hCount becomes 0
- frame_start  out  1  one-clk pulse when hCount and vCount both become 0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: sampled only on the rising edge of clk when reset_n==0. All outputs are registered.
- Reset values:
  - div counter = 0
  - pix_en = 0, hCount = 0, vCount = 0
  - hSync = 0, vSync = 0 (position 0,0 is inside both sync regions)
  - bright = 0, line_start = 0, frame_start = 0
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = 1 for exactly the one clk in which div == CLK_DIV-1.
  - The first pix_en occurs in the 4th clk after reset release.
- Counter advance: on a clk edge where pix_en==1:
  - If hCount == H_TOTAL-1: hCount -> 0.
    - If vCount == V_TOTAL-1, vCount -> 0; else vCount -> vCount+1.
  - Else hCount -> hCount+1 and vCount holds.
  - Both counters hold on all other edges.
- Decode, computed from the next counter values and registered with them, so all outputs are coherent in the same cycle (zero relative latency):
  - hSync = (hCount >= H_SYNC)
  - vSync = (vCount >= V_SYNC)
  - bright = (H_VIS_START <= hCount < H_VIS_END) and (V_VIS_START <= vCount < V_VIS_END)
- Pulses:
  - line_start = 1 only in the single clk in which hCount has just changed to 0.
  - frame_start = 1 only in the single clk in which (hCount,vCount) has just changed to (0,0); line_start is also 1 in that clk.
  - Neither pulse repeats while the counters hold for the remaining CLK_DIV-1 clocks.
  - Neither pulse asserts on exit from reset.
- Period:
  - Line = 800*4 = 3200 clk.
  - Frame = 3200*525 = 1,680,000 clk.
  - Visible window is 640x480: hCount 144..783, vCount 35..514.
- Boundaries:
  - hCount never reaches H_TOTAL and vCount never reaches V_TOTAL.
  - No out-of-range state is reachable.
  - Reset mid-frame returns everything to reset values on that edge, with no pulse emitted.
  - Reset held for many cycles keeps all outputs at reset values.
- Widths: 10-bit counters are sufficient, since 799 < 1024. No arithmetic overflow is possible.

Decomposition:
- Package vga_pkg holds the timing constants, which vga_bitchange also uses for its visible-area bounds:
  - H_TOTAL, H_SYNC, H_VIS_START, H_VIS_END
  - V_TOTAL, V_SYNC, V_VIS_START, V_VIS_END
  - CLK_DIV
- One sub-module: pix_clk_en, the CLK_DIV divider producing pix_en (clk, reset_n in; pix_en out).
- Counters, decode and pulses stay in vga_timing_gen.

Test Plan:
- Reset then release -> outputs hold reset values for 3 clk; pix_en=1 in clk 4; hCount=1 at the following edge; pix_en period is exactly 4 clk thereafter.
- Run one line -> hSync low for hCount 0..95 (384 clk), high 96..799; line_start period 3200 clk; hCount peaks at 799, then reads 0 with line_start=1 for 1 clk.
- Run one full frame -> frame_start pulses exactly 1,680,000 clk apart; vSync low for vCount 0..1 (6400 clk); vCount max 524.
- Visible window -> bright=1 first at (144,35) and last at (783,514); bright=0 at (143,35), (784,35), (144,34) and (144,515); bright count per frame = 307,200 pixels.
- Assert reset_n=0 for 1 clk at (500,300) -> next cycle all outputs at reset values with no line_start/frame_start; the timing sequence restarts identically to the first-reset case.
- Coherence check over a frame -> in every clk, hSync, vSync and bright match the decode of the hCount/vCount presented in that same clk (scoreboard model).
